// File: rtl/conv_layer_sequencer.sv
// Single-layer sequencer for a quantized conv/ReLU engine: streams biases, weights
// and the padded input map into the engine, tags its output bytes and recycles it.
module conv_layer_sequencer #(
  parameter int INPUT_CHANNELS  = 1,
  parameter int OUTPUT_CHANNELS = 32,
  parameter int KERNEL_SIZE     = 3,
  parameter int INPUT_WIDTH     = 30,
  parameter int INPUT_HEIGHT    = 30,
  localparam int IN_WORDS  = INPUT_CHANNELS * INPUT_HEIGHT * INPUT_WIDTH,
  localparam int W_WORDS   = OUTPUT_CHANNELS * INPUT_CHANNELS * KERNEL_SIZE * KERNEL_SIZE,
  localparam int OW        = INPUT_WIDTH - KERNEL_SIZE + 1,
  localparam int OH        = INPUT_HEIGHT - KERNEL_SIZE + 1,
  localparam int OUT_WORDS = OUTPUT_CHANNELS * OH * OW,
  localparam int BA_W      = (OUTPUT_CHANNELS > 1) ? $clog2(OUTPUT_CHANNELS) : 1,
  localparam int WA_W      = (W_WORDS > 1) ? $clog2(W_WORDS) : 1,
  localparam int IA_W      = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1,
  localparam int ROW_W     = (OH > 1) ? $clog2(OH) : 1,
  localparam int COL_W     = (OW > 1) ? $clog2(OW) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_start_i,
  output logic              cmd_busy_o,
  output logic              cmd_done_o,
  output logic              cmd_error_o,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [31:0]       s_data_i,
  output logic              eng_rstn_o,
  output logic              eng_start_o,
  input  logic              eng_done_i,
  output logic [31:0]       eng_bias_data_o,
  output logic              eng_bias_we_o,
  output logic [BA_W-1:0]   eng_bias_addr_o,
  output logic [7:0]        eng_weight_data_o,
  output logic              eng_weight_we_o,
  output logic [WA_W-1:0]   eng_weight_addr_o,
  output logic [7:0]        eng_input_data_o,
  output logic              eng_input_we_o,
  output logic [IA_W-1:0]   eng_input_addr_o,
  input  logic              eng_conv_valid_i,
  input  logic [7:0]        eng_conv_result_i,
  output logic              out_valid_o,
  output logic [7:0]        out_data_o,
  output logic [BA_W-1:0]   out_channel_o,
  output logic [ROW_W-1:0]  out_row_o,
  output logic [COL_W-1:0]  out_col_o,
  output logic              out_last_o
);

  localparam int MAX_WORDS = (IN_WORDS > W_WORDS) ?
                             ((IN_WORDS > OUTPUT_CHANNELS) ? IN_WORDS : OUTPUT_CHANNELS) :
                             ((W_WORDS > OUTPUT_CHANNELS) ? W_WORDS : OUTPUT_CHANNELS);
  localparam int LD_W   = $clog2(MAX_WORDS + 1);
  localparam int OC_W   = $clog2(OUT_WORDS + 3);
  localparam int OC_SAT = OUT_WORDS + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_BIAS, S_LOAD_WEIGHT, S_LOAD_INPUT, S_START, S_RUN, S_RELEASE, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [LD_W-1:0]   ld_cnt_q;
  logic [31:0]       bias_data_q;
  logic              bias_we_q;
  logic [BA_W-1:0]   bias_addr_q;
  logic [7:0]        weight_data_q;
  logic              weight_we_q;
  logic [WA_W-1:0]   weight_addr_q;
  logic [7:0]        input_data_q;
  logic              input_we_q;
  logic [IA_W-1:0]   input_addr_q;
  logic              eng_rstn_q;
  logic              eng_start_q;
  logic              out_valid_q;
  logic [7:0]        out_data_q;
  logic [BA_W-1:0]   out_ch_q;
  logic [ROW_W-1:0]  out_row_q;
  logic [COL_W-1:0]  out_col_q;
  logic              out_last_q;
  logic [BA_W-1:0]   ch_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [OC_W-1:0]   out_cnt_q;
  logic              error_q;

  logic              accept;
  logic              phase_last;
  logic              start_accept;
  logic              run_beat;
  logic [OC_W-1:0]   cnt_after;

  assign s_ready_o    = (state_q == S_LOAD_BIAS) || (state_q == S_LOAD_WEIGHT) ||
                        (state_q == S_LOAD_INPUT);
  assign cmd_busy_o   = (state_q != S_IDLE);
  assign cmd_done_o   = (state_q == S_DONE);
  assign accept       = s_valid_i && s_ready_o;
  assign start_accept = (state_q == S_IDLE) && cmd_start_i;
  assign run_beat     = (state_q == S_RUN) && eng_conv_valid_i;
  // Count including a beat that arrives together with eng_done.
  assign cnt_after    = out_cnt_q + {{(OC_W-1){1'b0}}, run_beat};

  always_comb begin
    phase_last = 1'b0;
    case (state_q)
      S_LOAD_BIAS:   phase_last = (ld_cnt_q == LD_W'(OUTPUT_CHANNELS - 1));
      S_LOAD_WEIGHT: phase_last = (ld_cnt_q == LD_W'(W_WORDS - 1));
      S_LOAD_INPUT:  phase_last = (ld_cnt_q == LD_W'(IN_WORDS - 1));
      default:       phase_last = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:        if (cmd_start_i) state_d = S_LOAD_BIAS;
      S_LOAD_BIAS:   if (accept && phase_last) state_d = S_LOAD_WEIGHT;
      S_LOAD_WEIGHT: if (accept && phase_last) state_d = S_LOAD_INPUT;
      S_LOAD_INPUT:  if (accept && phase_last) state_d = S_START;
      S_START:       state_d = S_RUN;
      S_RUN:         if (eng_done_i) state_d = S_RELEASE;
      S_RELEASE:     state_d = S_DONE;
      S_DONE:        state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Write strobes are registered, so each accepted beat shows up one cycle later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ld_cnt_q      <= '0;
      bias_data_q   <= '0;
      bias_we_q     <= 1'b0;
      bias_addr_q   <= '0;
      weight_data_q <= '0;
      weight_we_q   <= 1'b0;
      weight_addr_q <= '0;
      input_data_q  <= '0;
      input_we_q    <= 1'b0;
      input_addr_q  <= '0;
    end else begin
      bias_we_q   <= 1'b0;
      weight_we_q <= 1'b0;
      input_we_q  <= 1'b0;
      if (start_accept) begin
        ld_cnt_q <= '0;
      end else if (accept) begin
        ld_cnt_q <= phase_last ? '0 : ld_cnt_q + 1'b1;
        case (state_q)
          S_LOAD_BIAS: begin
            bias_we_q   <= 1'b1;
            bias_addr_q <= ld_cnt_q[BA_W-1:0];
            bias_data_q <= s_data_i;
          end
          S_LOAD_WEIGHT: begin
            weight_we_q   <= 1'b1;
            weight_addr_q <= ld_cnt_q[WA_W-1:0];
            weight_data_q <= s_data_i[7:0];
          end
          S_LOAD_INPUT: begin
            input_we_q   <= 1'b1;
            input_addr_q <= ld_cnt_q[IA_W-1:0];
            input_data_q <= s_data_i[7:0];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      eng_rstn_q  <= 1'b0;
      eng_start_q <= 1'b0;
    end else begin
      eng_rstn_q  <= (state_d != S_RELEASE);
      eng_start_q <= (state_q == S_START);
    end
  end

  // Tags wrap naturally, so beats past the expected count restart at position zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
      ch_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      out_cnt_q   <= '0;
      error_q     <= 1'b0;
    end else begin
      out_valid_q <= run_beat;
      if (start_accept) begin
        ch_q      <= '0;
        row_q     <= '0;
        col_q     <= '0;
        out_cnt_q <= '0;
        error_q   <= 1'b0;
      end else begin
        if (run_beat) begin
          out_data_q <= eng_conv_result_i;
          out_ch_q   <= ch_q;
          out_row_q  <= row_q;
          out_col_q  <= col_q;
          out_last_q <= (out_cnt_q == OC_W'(OUT_WORDS - 1));
          if (col_q == COL_W'(OW - 1)) begin
            col_q <= '0;
            if (row_q == ROW_W'(OH - 1)) begin
              row_q <= '0;
              ch_q  <= (ch_q == BA_W'(OUTPUT_CHANNELS - 1)) ? '0 : ch_q + 1'b1;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end else begin
            col_q <= col_q + 1'b1;
          end
          if (out_cnt_q != OC_W'(OC_SAT)) out_cnt_q <= out_cnt_q + 1'b1;
          if (out_cnt_q >= OC_W'(OUT_WORDS)) error_q <= 1'b1;
        end
        if ((state_q == S_RUN) && eng_done_i && (cnt_after != OC_W'(OUT_WORDS)))
          error_q <= 1'b1;
      end
    end
  end

  assign cmd_error_o       = error_q;
  assign eng_rstn_o        = eng_rstn_q;
  assign eng_start_o       = eng_start_q;
  assign eng_bias_data_o   = bias_data_q;
  assign eng_bias_we_o     = bias_we_q;
  assign eng_bias_addr_o   = bias_addr_q;
  assign eng_weight_data_o = weight_data_q;
  assign eng_weight_we_o   = weight_we_q;
  assign eng_weight_addr_o = weight_addr_q;
  assign eng_input_data_o  = input_data_q;
  assign eng_input_we_o    = input_we_q;
  assign eng_input_addr_o  = input_addr_q;
  assign out_valid_o       = out_valid_q;
  assign out_data_o        = out_data_q;
  assign out_channel_o     = out_ch_q;
  assign out_row_o         = out_row_q;
  assign out_col_o         = out_col_q;
  assign out_last_o        = out_last_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Randomized bench for conv_layer_sequencer: expected writes and tagged outputs come
// from a queue-based reference model built from the stream order and output geometry.
module tb_conv_layer_sequencer;

  localparam int OC = 2, KS = 3, IW = 5, IH = 5;
  localparam int NB = OC, NW = OC * KS * KS, NI = IW * IH;
  localparam int OWD = IW - KS + 1, OHT = IH - KS + 1;
  localparam int NOUT = OC * OHT * OWD;
  localparam int NBEATS = NB + NW + NI;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_start = 1'b0;
  logic        cmd_busy, cmd_done, cmd_error;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        eng_rstn, eng_start;
  logic        eng_done = 1'b0;
  logic [31:0] bias_data;
  logic        bias_we;
  logic [0:0]  bias_addr;
  logic [7:0]  weight_data;
  logic        weight_we;
  logic [4:0]  weight_addr;
  logic [7:0]  input_data;
  logic        input_we;
  logic [4:0]  input_addr;
  logic        conv_valid = 1'b0;
  logic [7:0]  conv_result = '0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [0:0]  out_channel;
  logic [1:0]  out_row, out_col;
  logic        out_last;

  conv_layer_sequencer #(
    .INPUT_CHANNELS(1), .OUTPUT_CHANNELS(OC), .KERNEL_SIZE(KS),
    .INPUT_WIDTH(IW), .INPUT_HEIGHT(IH)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cmd_start_i(cmd_start), .cmd_busy_o(cmd_busy),
    .cmd_done_o(cmd_done), .cmd_error_o(cmd_error), .s_valid_i(s_valid),
    .s_ready_o(s_ready), .s_data_i(s_data), .eng_rstn_o(eng_rstn),
    .eng_start_o(eng_start), .eng_done_i(eng_done), .eng_bias_data_o(bias_data),
    .eng_bias_we_o(bias_we), .eng_bias_addr_o(bias_addr),
    .eng_weight_data_o(weight_data), .eng_weight_we_o(weight_we),
    .eng_weight_addr_o(weight_addr), .eng_input_data_o(input_data),
    .eng_input_we_o(input_we), .eng_input_addr_o(input_addr),
    .eng_conv_valid_i(conv_valid), .eng_conv_result_i(conv_result),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_channel_o(out_channel),
    .out_row_o(out_row), .out_col_o(out_col), .out_last_o(out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int addr; logic [31:0] data; int cyc; } wr_t;
  typedef struct { logic [7:0] data; int ch; int row; int col; int last; int cyc; } out_t;

  wr_t  expWr[$];
  out_t expOut[$];
  wr_t  ew;
  out_t eo;
  int   checkCount = 0;
  int   failCount = 0;
  int   startCount = 0;
  int   startCyc = 0;
  int   baseStart = 0;
  int   lastAcceptNeg = 0;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  // Observes engine write ports, start pulses and tagged output at every falling edge.
  always @(negedge clk) begin
    if (eng_start) begin
      startCount++;
      startCyc = cyc;
    end
    if (bias_we || weight_we || input_we) begin
      checkOutput("single_we", int'(bias_we) + int'(weight_we) + int'(input_we), 1);
      if (expWr.size() == 0) begin
        checkOutput("unexpected_write", 1, 0);
      end else begin
        ew = expWr.pop_front();
        checkOutput("wr_kind", bias_we ? 0 : (weight_we ? 1 : 2), ew.kind);
        checkOutput("wr_addr", bias_we ? int'(bias_addr) : (weight_we ? int'(weight_addr) : int'(input_addr)), ew.addr);
        checkOutput("wr_data", bias_we ? bias_data : (weight_we ? {24'd0, weight_data} : {24'd0, input_data}), ew.data);
        checkOutput("wr_cycle", cyc, ew.cyc);
      end
    end
    if (out_valid) begin
      if (expOut.size() == 0) begin
        checkOutput("unexpected_out", 1, 0);
      end else begin
        eo = expOut.pop_front();
        checkOutput("out_data", out_data, eo.data);
        checkOutput("out_channel", out_channel, eo.ch);
        checkOutput("out_row", out_row, eo.row);
        checkOutput("out_col", out_col, eo.col);
        checkOutput("out_last", out_last, eo.last);
        checkOutput("out_cycle", cyc, eo.cyc);
      end
    end
  end

  task automatic issueStart();
    cmd_start = 1'b1;
    @(posedge clk);
    nextCycle();
    cmd_start = 1'b0;
    checkOutput("start_busy", cmd_busy, 1);
    checkOutput("start_ready", s_ready, 1);
    checkOutput("start_error_clear", cmd_error, 0);
  endtask

  // Streams nBeats beats of the bias/weight/input sequence with random s_valid gaps.
  task automatic applyStimulus(input int stallPct, input int nBeats);
    int idx = 0;
    int guard = 0;
    int negCyc;
    logic rdy;
    logic [31:0] d;
    wr_t w;
    baseStart = startCount;
    d = $urandom;
    while (idx < nBeats && guard < 2000) begin
      s_valid = ($urandom_range(0, 99) >= stallPct);
      s_data = d;
      rdy = s_ready;
      negCyc = cyc;
      @(posedge clk);
      if (s_valid && rdy) begin
        if (idx < NB)           begin w.kind = 0; w.addr = idx;           w.data = d; end
        else if (idx < NB + NW) begin w.kind = 1; w.addr = idx - NB;      w.data = d & 32'hFF; end
        else                    begin w.kind = 2; w.addr = idx - NB - NW; w.data = d & 32'hFF; end
        w.cyc = negCyc + 1;
        expWr.push_back(w);
        lastAcceptNeg = negCyc;
        idx++;
        d = $urandom;
      end
      guard++;
      nextCycle();
    end
    s_valid = 1'b0;
    if (idx < nBeats) checkOutput("load_timeout", idx, nBeats);
  endtask

  // Plays the engine: waits for its start, emits nPulses results, then raises done.
  task automatic runEngine(input int nPulses, input bit sameCycleDone, input int expErr);
    int guard = 0;
    int emitted = 0;
    int negCyc;
    int j;
    out_t o;
    checkOutput("ready_low_after_load", s_ready, 0);
    while (startCount == baseStart && guard < 8) begin
      nextCycle();
      guard++;
    end
    checkOutput("start_count", startCount, baseStart + 1);
    checkOutput("start_latency", startCyc, lastAcceptNeg + 2);
    nextCycle();
    checkOutput("start_one_cycle", eng_start, 0);
    checkOutput("ready_low_run", s_ready, 0);
    checkOutput("writes_drained", expWr.size(), 0);
    guard = 0;
    while (emitted < nPulses && guard < 500) begin
      conv_valid = ($urandom_range(0, 1) == 1);
      conv_result = 8'($urandom);
      if (conv_valid && sameCycleDone && emitted == nPulses - 1) eng_done = 1'b1;
      negCyc = cyc;
      @(posedge clk);
      if (conv_valid) begin
        j = emitted % NOUT;
        o.data = conv_result;
        o.ch = j / (OHT * OWD);
        o.row = (j / OWD) % OHT;
        o.col = j % OWD;
        o.last = (emitted == NOUT - 1) ? 1 : 0;
        o.cyc = negCyc + 1;
        expOut.push_back(o);
        emitted++;
      end
      guard++;
      nextCycle();
    end
    conv_valid = 1'b0;
    if (emitted < nPulses) checkOutput("pulse_timeout", emitted, nPulses);
    if (!eng_done) begin
      eng_done = 1'b1;
      @(posedge clk);
      nextCycle();
    end
    checkOutput("release_rstn", eng_rstn, 0);
    checkOutput("release_busy", cmd_busy, 1);
    checkOutput("release_no_done", cmd_done, 0);
    eng_done = 1'b0;
    nextCycle();
    checkOutput("done_rstn", eng_rstn, 1);
    checkOutput("done_pulse", cmd_done, 1);
    nextCycle();
    checkOutput("done_one_cycle", cmd_done, 0);
    checkOutput("idle_busy", cmd_busy, 0);
    checkOutput("run_error", cmd_error, expErr);
    checkOutput("outputs_drained", expOut.size(), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) nextCycle();
    checkOutput("reset_outputs",
                {cmd_busy, cmd_done, cmd_error, s_ready, eng_start, bias_we, weight_we,
                 input_we, out_valid, out_last}, 0);
    checkOutput("reset_rstn", eng_rstn, 0);
    rst = 1'b0;
    nextCycle();
    checkOutput("post_reset_rstn", eng_rstn, 1);
    checkOutput("post_reset_idle", cmd_busy, 0);

    $display("[TB] full load, no stalls, exact output count");
    issueStart();
    applyStimulus(0, NBEATS);
    runEngine(NOUT, 1'b0, 0);

    $display("[TB] stalled load, last output together with done");
    issueStart();
    applyStimulus(50, NBEATS);
    runEngine(NOUT, 1'b1, 0);

    $display("[TB] short output count");
    issueStart();
    applyStimulus(30, NBEATS);
    runEngine(NOUT - 1, 1'b0, 1);
    nextCycle();
    checkOutput("error_sticky_idle", cmd_error, 1);

    $display("[TB] extra output beat");
    issueStart();
    applyStimulus(20, NBEATS);
    runEngine(NOUT + 1, 1'b0, 1);

    $display("[TB] reset during weight load");
    issueStart();
    applyStimulus(0, NB + 5);
    rst = 1'b1;
    @(posedge clk);
    nextCycle();
    checkOutput("rst_busy", cmd_busy, 0);
    checkOutput("rst_we", {bias_we, weight_we, input_we}, 0);
    checkOutput("rst_rstn", eng_rstn, 0);
    checkOutput("rst_ready", s_ready, 0);
    rst = 1'b0;
    nextCycle();
    checkOutput("rst_no_done", cmd_done, 0);
    checkOutput("rst_writes_drained", expWr.size(), 0);
    issueStart();
    applyStimulus(10, NBEATS);
    runEngine(NOUT, 1'b0, 0);

    $display("[TB] cmd_start held high");
    cmd_start = 1'b1;
    @(posedge clk);
    nextCycle();
    applyStimulus(0, NBEATS);
    runEngine(NOUT, 1'b0, 0);
    nextCycle();
    checkOutput("restart_busy", cmd_busy, 1);
    checkOutput("restart_ready", s_ready, 1);
    cmd_start = 1'b0;
    applyStimulus(0, NBEATS);
    runEngine(NOUT, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/conv_layer_sequencer.md
# conv_layer_sequencer

Sequencer that owns one quantized conv/ReLU engine for a single layer. It streams biases, weights and the padded input map from a 32-bit load stream into the engine's write ports, then pulses the engine start. It tags each output byte with channel/row/col, checks the output count, and recycles the engine through its active-low reset so the next layer can run.

## Interface
- INPUT_CHANNELS, 1, input channels (engine supports 1)
- OUTPUT_CHANNELS, 32, output channels
- KERNEL_SIZE, 3, kernel edge
- INPUT_WIDTH, 30, padded input width
- INPUT_HEIGHT, 30, padded input height
- Derived values:
  - IN_WORDS = INPUT_CHANNELS·INPUT_HEIGHT·INPUT_WIDTH
  - W_WORDS = OUTPUT_CHANNELS·INPUT_CHANNELS·KERNEL_SIZE²
  - OW = INPUT_WIDTH−KERNEL_SIZE+1, OH = INPUT_HEIGHT−KERNEL_SIZE+1
  - OUT_WORDS = OUTPUT_CHANNELS·OH·OW
- Ports:
  - clk  in  1  single clock, rising edge
  - rst  in  1  synchronous, active-high reset
  - cmd_start  in  1  start request; ignored unless IDLE
  - cmd_busy  out  1  high in every state except IDLE
  - cmd_done  out  1  one-cycle completion pulse
  - cmd_error  out  1  sticky count-mismatch flag; cleared on an accepted cmd_start
  - s_valid / s_ready / s_data  in / out / 32  load stream
  - eng_rstn  out  1  engine reset, active-low
  - eng_start  out  1  one-cycle engine start
  - eng_done  in  1  engine completion level
  - eng_bias_data/_we/_addr  out  32/1/clog2(OUTPUT_CHANNELS)
  - eng_weight_data/_we/_addr  out  8/1/clog2(W_WORDS)
  - eng_input_data/_we/_addr  out  8/1/clog2(IN_WORDS)
  - eng_conv_valid / eng_conv_result  in  1 / 8  engine output
  - out_valid / out_data  out  1 / 8  tagged output
  - out_channel / out_row / out_col  out  clog2 widths  output position tags
  - out_last  out  1  marks the final output byte

## Operation
- States: IDLE, LOAD_BIAS, LOAD_WEIGHT, LOAD_INPUT, START, RUN, RELEASE, DONE.
- IDLE → LOAD_BIAS on cmd_start. This clears cmd_error, the load address counter and the output counters.
- Load phases:
  - s_ready=1 only in LOAD_*. A beat transfers when s_valid&&s_ready.
  - Stream order: OUTPUT_CHANNELS bias words (full 32 bits), then W_WORDS weight beats, then IN_WORDS input beats. Weight and input beats use s_data[7:0]; s_data[31:8] is ignored.
  - Per accepted beat: the phase's _we, _addr (= beat index within phase) and data are registered and appear the next cycle. Exactly one _we is high per accepted beat.
  - On the last beat of a phase: address counter → 0 and the state advances. LOAD_INPUT's last beat goes to START.
- START: eng_start=1 for exactly one cycle → RUN.
- RUN:
  - Each eng_conv_valid cycle produces one output beat; output counter +1.
  - Tags advance col 0..OW−1, then row 0..OH−1, then channel 0..OUTPUT_CHANNELS−1, wrapping each inner counter to 0.
  - out_last=1 when the tagged index is OUT_WORDS−1.
  - Beats beyond OUT_WORDS are still forwarded, with tags wrapped to 0, and set cmd_error.
  - eng_done=1 → RELEASE. If count≠OUT_WORDS at that point, cmd_error=1.
- RELEASE: eng_rstn=0 for one cycle (engine returns to its idle state) → DONE.
- DONE: cmd_done=1 for one cycle → IDLE.
- cmd_start is ignored outside IDLE, including while cmd_done pulses.

## Timing
- Reset values: every output 0, including eng_rstn=0 (engine held in reset while rst=1) and s_ready=0. State=IDLE.
- eng_rstn=1 in all states except RELEASE; registered.
- Load throughput: 1 beat/cycle. s_valid stalls insert idle cycles with _we=0.
- Load latency: write strobe appears 1 cycle after the accepting edge. eng_start rises 2 cycles after the last input beat is accepted (last write, then START).
- Output latency: out_valid rises 1 cycle after eng_conv_valid; registered, no backpressure.
- Same-cycle eng_conv_valid and eng_done: the output beat is forwarded and counted before the count check.
- rst mid-operation: immediate return to IDLE, all strobes dropped, engine held in reset. No cmd_done is issued.
- eng_done seen in any state other than RUN is ignored.

## Test plan
- Parameters: OUTPUT_CHANNELS=2, K=3, W=H=5, so bias=2, weights=18, input=25, OUT_WORDS=18.
- Full load, no stalls, 45 beats: bias_we at addr 0,1; weight_we at addr 0..17; input_we at addr 0..24, each one cycle after acceptance. eng_start pulses once, 2 cycles after beat 45.
- Random s_valid gaps (50%): identical write sequence and addresses, no duplicate strobes, s_ready low outside load phases.
- Engine model emits 18 conv_valid pulses, then done → 18 out_valid beats, tags (0,0,0)…(1,2,2), out_last only on the 18th. eng_rstn low 1 cycle, cmd_done 1 cycle later, cmd_error=0.
- Model emits 17 pulses, then done → cmd_error=1, stays high through IDLE, clears on the next cmd_start.
- rst asserted mid-LOAD_WEIGHT → next cycle IDLE, all we=0, eng_rstn=0, cmd_busy=0. A fresh cmd_start then reloads from bias addr 0.
- cmd_start held high continuously → exactly one run per IDLE visit. The second run starts the cycle after cmd_done.
